pwm_gen8: RTL and testbench



---
 rtl/pwm_gen8.sv | 73 +++++++
 tb/tb_pwm_gen8.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pwm_gen8.sv
// rtl/pwm_gen8.sv - 8-channel double-buffered PWM generator with per-channel end-of-period pulse
module pwm_gen8 #(
  parameter int CH = 8,
  parameter int W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en_in,
  input  logic [CH*W-1:0] t_in,
  input  logic [CH*W-1:0] d_in,
  output logic [CH-1:0]   pwm_out,
  output logic [CH-1:0]   period_done,
  output logic            busy
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic r_busy;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_tsh;
    logic [W-1:0] r_dsh;
    logic         r_pwm;
    logic         r_done;
    logic [W-1:0] w_t;
    logic [W-1:0] w_d;
    logic         w_wrap;

    assign w_t    = t_in[g*W +: W];
    assign w_d    = d_in[g*W +: W];
    assign w_wrap = (r_cnt == r_tsh - ONE);

    // Shadows only reload while idle/degenerate or at a wrap, so a frame is never altered mid-flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= '0;
        r_tsh  <= '0;
        r_dsh  <= '0;
        r_pwm  <= 1'b0;
        r_done <= 1'b0;
      end else if (!en_in[g] || r_tsh == '0) begin
        r_cnt  <= '0;
        r_tsh  <= w_t;
        r_dsh  <= w_d;
        r_pwm  <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_pwm <= (r_cnt < r_dsh);
        if (w_wrap) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          r_tsh  <= w_t;
          r_dsh  <= w_d;
        end else begin
          r_cnt  <= r_cnt + ONE;
          r_done <= 1'b0;
        end
      end
    end

    assign pwm_out[g]     = r_pwm;
    assign period_done[g] = r_done;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= |en_in;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_pwm_gen8.sv
// tb/tb_pwm_gen8.sv - self-checking bench for pwm_gen8 against a frame-queue reference model
module tb_pwm_gen8;
  localparam int CH = 8;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en_in;
  logic [CH*W-1:0] t_in;
  logic [CH*W-1:0] d_in;
  logic [CH-1:0]   pwm_out;
  logic [CH-1:0]   period_done;
  logic            busy;

  always #5 clk = ~clk;

  pwm_gen8 #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .t_in(t_in), .d_in(d_in),
    .pwm_out(pwm_out), .period_done(period_done), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: each channel plays out a whole frame from a queue of {done, pwm} cycles.
  int unsigned m_tsh [CH];
  int unsigned m_dsh [CH];
  logic [1:0]  m_q   [CH][$];
  logic [CH-1:0] e_pwm;
  logic [CH-1:0] e_done;
  logic          e_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input int unsigned t, input int unsigned d);
    t_in[i*W +: W] = t;
    d_in[i*W +: W] = d;
  endtask

  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      int unsigned ti;
      int unsigned di;
      logic [1:0]  e;
      ti = t_in[i*W +: W];
      di = d_in[i*W +: W];
      e  = 2'b00;
      if (rst) begin
        m_q[i].delete();
        m_tsh[i] = 0;
        m_dsh[i] = 0;
      end else if (!en_in[i]) begin
        m_q[i].delete();
        m_tsh[i] = ti;
        m_dsh[i] = di;
      end else begin
        if (m_q[i].size() == 0 && m_tsh[i] > 0)
          for (int unsigned k = 0; k < m_tsh[i]; k++)
            m_q[i].push_back({k == m_tsh[i] - 1, k < m_dsh[i]});
        if (m_q[i].size() == 0) begin
          m_tsh[i] = ti;
          m_dsh[i] = di;
        end else begin
          e = m_q[i].pop_front();
          if (e[1]) begin
            m_tsh[i] = ti;
            m_dsh[i] = di;
          end
        end
      end
      e_pwm[i]  = e[0];
      e_done[i] = e[1];
    end
    e_busy = rst ? 1'b0 : |en_in;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("period_done", 32'(period_done), 32'(e_done));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1; en_in = '0; t_in = '0; d_in = '0;
    for (int i = 0; i < CH; i++) begin m_tsh[i] = 0; m_dsh[i] = 0; end
    run(2);
    rst = 1'b0;

    set_ch(0, 10, 3); en_in[0] = 1'b1;
    run(25);

    set_ch(1, 8, 2); en_in[1] = 1'b1;
    run(11);
    set_ch(1, 8, 6);
    run(20);

    en_in[2] = 1'b1;
    set_ch(2, 5, 0);  run(12);
    set_ch(2, 5, 5);  run(12);
    set_ch(2, 5, 9);  run(12);
    set_ch(2, 5, 32'hFFFF_FFF0); run(12);
    set_ch(2, 0, 3);  run(8);
    set_ch(2, 1, 1);  run(8);
    set_ch(2, 3, 1);  run(8);

    set_ch(3, 20, 10); en_in[3] = 1'b1;
    run(5);
    en_in[3] = 1'b0;
    run(2);
    set_ch(3, 4, 1); en_in[3] = 1'b1;
    run(10);

    for (int i = 0; i < CH; i++) set_ch(i, 3 + i, 1 + i);
    en_in = '1;
    run(60);
    en_in = '0;
    run(3);

    en_in = '1;
    run(7);
    rst = 1'b1; run(1);
    rst = 1'b0; run(20);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_ch($urandom_range(0, CH - 1), $urandom_range(0, 12), $urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0)
        en_in[$urandom_range(0, CH - 1)] ^= 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
